// File: rtl/gate_chk_pkg.sv
// Shared types and truth tables for the 2-input gate sweep checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Expected gate output per vector, bit index = {a,b}.
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] XNOR_TT = 4'b1001;

  // Expected output bit for a given vector index.
  function automatic logic tt_bit(input logic [3:0] tt, input logic [1:0] idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/gate_sweep_checker.sv
// Drives a 2-input gate through 00,01,10,11, samples its output after a
// programmable settle time and reports per-vector mismatches and overall pass.
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter logic [3:0]  EXPECT = OR_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, state_next;
  logic [1:0] idx, idx_next;
  logic [3:0] cnt, cnt_next;
  logic [3:0] fail_next;
  logic       pass_next;
  logic       mismatch;

  // X or Z on the gate output is treated as a mismatch.
  always_comb begin
    mismatch = (y_in !== tt_bit(EXPECT, idx));
  end

  // Next-state and datapath updates for the sweep sequence.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    fail_next  = fail_mask;
    pass_next  = pass;
    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_next   = '0;
          cnt_next   = '0;
          fail_next  = '0;
          pass_next  = 1'b0;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_next = cnt + 4'd1;
        if (cnt == SETTLE_LAST) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        fail_next[idx] = mismatch;
        if (idx == 2'd3) begin
          // pass is resolved from the final mask on entry to DONE so it is
          // already valid during the done cycle.
          pass_next  = ~|fail_next;
          state_next = ST_DONE;
        end else begin
          idx_next   = idx + 2'd1;
          cnt_next   = '0;
          state_next = ST_SETTLE;
        end
      end
      ST_DONE: begin
        pass_next  = ~|fail_mask;
        idx_next   = '0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters, result flags and registered gate inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      fail_mask <= '0;
      pass      <= 1'b0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      cnt       <= cnt_next;
      fail_mask <= fail_next;
      pass      <= pass_next;
      a_out     <= idx_next[1];
      b_out     <= idx_next[0];
    end
  end

  // Status decodes of the current state.
  always_comb begin
    busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: three checker instances around a behavioural 2-input gate.
module tb_gate_sweep_checker;
  import gate_chk_pkg::*;

  localparam logic [1:0] G_OR  = 2'd0;
  localparam logic [1:0] G_AND = 2'd1;
  localparam logic [1:0] G_HI  = 2'd2;
  localparam logic [1:0] G_LO  = 2'd3;

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] y_v;
  logic [2:0] a_v, b_v, busy_v, done_v, pass_v;
  logic [3:0] mask_v [3];
  logic [1:0] gsel [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gate_fn(input logic [1:0] sel, input logic a, input logic b);
    case (sel)
      G_OR:    return a | b;
      G_AND:   return a & b;
      G_HI:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    y_v = '0;
    for (int i = 0; i < 3; i++) y_v[i] = gate_fn(gsel[i], a_v[i], b_v[i]);
  end

  gate_sweep_checker #(.SETTLE(2), .EXPECT(OR_TT)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .y_in(y_v[0]),
    .a_out(a_v[0]), .b_out(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .fail_mask(mask_v[0]));

  gate_sweep_checker #(.SETTLE(2), .EXPECT(AND_TT)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .y_in(y_v[1]),
    .a_out(a_v[1]), .b_out(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .fail_mask(mask_v[1]));

  gate_sweep_checker #(.SETTLE(1), .EXPECT(OR_TT)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .y_in(y_v[2]),
    .a_out(a_v[2]), .b_out(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .fail_mask(mask_v[2]));

  // One full sweep on instance u; checks every cycle from edge 0 to one past done.
  task automatic run_sweep(input int u, input int settle, input logic [3:0] exp_mask,
                           input string tag);
    int         last;
    int         v;
    logic [3:0] obs, exp;
    last = 4 * (settle + 1) + 1;
    start_v[u] = 1'b1;
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    checks++;
    if ({pass_v[u], mask_v[u]} !== 5'b0) begin
      errors++;
      $display("FAIL %s clear_at_start got pass=%b mask=%b want 0 0000", tag, pass_v[u], mask_v[u]);
    end
    for (int c = 1; c <= last + 1; c++) begin
      if (c < last) begin
        v   = (c - 1) / (settle + 1);
        obs = {a_v[u], b_v[u], busy_v[u], done_v[u]};
        exp = {v[1], v[0], 1'b1, 1'b0};
      end else if (c == last) begin
        obs = {2'b00, busy_v[u], done_v[u]};
        exp = 4'b0001;
      end else begin
        obs = {a_v[u], b_v[u], busy_v[u], done_v[u]};
        exp = 4'b0000;
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cycle%0d {a,b,busy,done} got %b want %b", tag, c, obs, exp);
      end
      if (c >= last) begin
        checks++;
        if ({pass_v[u], mask_v[u]} !== {exp_mask == 4'b0, exp_mask}) begin
          errors++;
          $display("FAIL %s result cycle%0d got pass=%b mask=%b want pass=%b mask=%b",
                   tag, c, pass_v[u], mask_v[u], exp_mask == 4'b0, exp_mask);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start_v = '1;
    gsel[0] = G_HI; gsel[1] = G_LO; gsel[2] = G_AND;
    #12;
    checks++;
    if ({a_v, b_v, busy_v, done_v, pass_v, mask_v[0], mask_v[1], mask_v[2]} !== 27'b0) begin
      errors++;
      $display("FAIL reset_outputs got a=%b b=%b busy=%b done=%b pass=%b want all 0",
               a_v, b_v, busy_v, done_v, pass_v);
    end
    checks++;
    if (dut_a.state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d want %0d", dut_a.state, ST_IDLE);
    end
    start_v = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({a_v, b_v, busy_v, done_v, pass_v} !== 15'b0) begin
        errors++;
        $display("FAIL post_reset_idle%0d got a=%b b=%b busy=%b done=%b pass=%b want all 0",
                 i, a_v, b_v, busy_v, done_v, pass_v);
      end
    end
  endtask

  task automatic test_or_gate();
    gsel[0] = G_OR;
    run_sweep(0, 2, 4'b0000, "or_vs_or");
  endtask

  task automatic test_and_gate();
    gsel[0] = G_AND;
    run_sweep(0, 2, 4'b0110, "and_vs_or");
    gsel[1] = G_AND;
    run_sweep(1, 2, 4'b0000, "and_vs_and");
  endtask

  task automatic test_stuck();
    gsel[0] = G_HI;
    run_sweep(0, 2, 4'b0001, "tied1_vs_or");
    gsel[0] = G_LO;
    run_sweep(0, 2, 4'b1110, "tied0_vs_or");
  endtask

  task automatic test_back_to_back();
    int         ph;
    int         v;
    int         n_done;
    logic [1:0] obs, exp;
    n_done  = 0;
    gsel[2] = G_OR;
    start_v[2] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      ph  = c % 10;
      obs = {busy_v[2], done_v[2]};
      exp = {(ph >= 1 && ph <= 8), (ph == 9)};
      if (done_v[2]) n_done++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b cycle%0d {busy,done} got %b want %b", c, obs, exp);
      end
      if (ph >= 1 && ph <= 8) begin
        v = (ph - 1) / 2;
        checks++;
        if ({a_v[2], b_v[2]} !== v[1:0]) begin
          errors++;
          $display("FAIL b2b_vec cycle%0d got %b%b want %b", c, a_v[2], b_v[2], v[1:0]);
        end
      end
      if (ph == 9) begin
        checks++;
        if ({pass_v[2], mask_v[2]} !== 5'b10000) begin
          errors++;
          $display("FAIL b2b_result cycle%0d got pass=%b mask=%b want 1 0000", c, pass_v[2], mask_v[2]);
        end
      end
    end
    start_v[2] = 1'b0;
    checks++;
    if (n_done != 4) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want 4", n_done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_v[2], done_v[2]} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_no_queue got busy=%b done=%b want 0 0", busy_v[2], done_v[2]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int seen;
    gsel[0] = G_OR;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({a_v[0], b_v[0], busy_v[0]} !== 3'b101) begin
      errors++;
      $display("FAIL mid_vec2 got a=%b b=%b busy=%b want 1 0 1", a_v[0], b_v[0], busy_v[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], mask_v[0]} !== 9'b0) begin
      errors++;
      $display("FAIL mid_async_reset got a=%b b=%b busy=%b done=%b pass=%b mask=%b want all 0",
               a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], mask_v[0]);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_no_done got %0d active cycles want 0", seen);
    end
    run_sweep(0, 2, 4'b0000, "or_after_reset");
  endtask

  initial begin
    rst     = 1'b1;
    start_v = '0;
    test_reset();
    test_or_gate();
    test_and_gate();
    test_stuck();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
